// File: rtl/enc16to4_req_if.sv
// Request/code bundle for the 16-to-4 request encoder.
// The slave side is the encoder itself; the master side feeds requests and consumes codes.
interface enc16to4_req_if;
    logic [15:0] in;
    logic        out_ready;
    logic        out_valid;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic [15:0] pending;
    logic        overrun;
    logic        busy;

    modport master (
        output in, out_ready,
        input  out_valid, A, B, C, D, pending, overrun, busy
    );

    modport slave (
        input  in, out_ready,
        output out_valid, A, B, C, D, pending, overrun, busy
    );
endinterface

// File: rtl/enc16to4_req.sv
// Sequential 16-to-4 request encoder.
// Request pulses collect in a pending bitmap. The highest-numbered pending line
// moves into a one-entry output stage, which presents its code as {A,B,C,D}
// under a valid/ready handshake. A line held in the output stage is no longer
// pending, so a fresh pulse on it simply re-arms it and is not an overrun.
module enc16to4_req (
    input  logic            clk,
    input  logic            rst_n,
    enc16to4_req_if.slave   bus
);

    logic [15:0] pending_p1;
    logic [3:0]  code_p1;
    logic        vld_p1;
    logic        overrun_p1;

    logic [3:0]  sel;
    logic        load;
    logic [15:0] clr_mask;

    // Index of the highest set bit; only meaningful when v is non-zero.
    function automatic logic [3:0] msb_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = i[3:0];
        end
        return idx;
    endfunction

    // Select the next line to issue and decide whether the output stage can take it.
    always_comb begin
        sel      = msb_index(pending_p1);
        load     = (|pending_p1) & (~vld_p1 | bus.out_ready);
        clr_mask = 16'h0000;
        if (load) clr_mask = 16'h0001 << sel;
    end

    // ---- stage p1: pending bitmap, output stage and overrun flag ----
    // Pending bits merge new pulses after the issued bit is removed, so a pulse
    // on the line being loaded in the same edge survives and is reissued later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_p1 <= 16'h0000;
            code_p1    <= 4'd0;
            vld_p1     <= 1'b0;
            overrun_p1 <= 1'b0;
        end else begin
            pending_p1 <= (pending_p1 & ~clr_mask) | bus.in;
            overrun_p1 <= |(bus.in & pending_p1 & ~clr_mask);
            if (load) begin
                code_p1 <= sel;
                vld_p1  <= 1'b1;
            end else if (vld_p1 && bus.out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // Drive the registered state onto the bus; busy is derived from that state.
    always_comb begin
        bus.pending   = pending_p1;
        bus.out_valid = vld_p1;
        bus.A         = code_p1[3];
        bus.B         = code_p1[2];
        bus.C         = code_p1[1];
        bus.D         = code_p1[0];
        bus.overrun   = overrun_p1;
        bus.busy      = (|pending_p1) | vld_p1;
    end

endmodule

// File: tb/tb_enc16to4_req.sv
// Bench for enc16to4_req: directed scenarios followed by random traffic, all
// checked against a behavioural model of pending requests and the output slot.
module tb_enc16to4_req;

    logic clk;
    logic rst_n;

    enc16to4_req_if bus ();

    enc16to4_req dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: a set of pending lines plus one output slot.
    bit       m_pend [16];
    bit       m_vld;
    int       m_code;
    bit       m_ovr;
    int       accepted [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_pend_vec();
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < 16; i++) if (m_pend[i]) v = v | (16'h0001 << i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_vld  = 1'b0;
        m_code = 0;
        m_ovr  = 1'b0;
        accepted.delete();
    endtask

    // One clock edge of the model, given the inputs present at that edge.
    task automatic model_step(input logic [15:0] iv, input logic rdy);
        int  hi;
        bit  ld;
        hi = -1;
        for (int i = 15; i >= 0; i--) if (m_pend[i] && hi < 0) hi = i;
        ld = (hi >= 0) && (!m_vld || rdy);
        if (m_vld && rdy) accepted.push_back(m_code);
        m_ovr = 1'b0;
        for (int i = 0; i < 16; i++)
            if (iv[i] && m_pend[i] && !(ld && i == hi)) m_ovr = 1'b1;
        if (ld) begin
            m_pend[hi] = 1'b0;
            m_code     = hi;
            m_vld      = 1'b1;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        for (int i = 0; i < 16; i++) if (iv[i]) m_pend[i] = 1'b1;
    endtask

    task automatic check_all();
        bit any;
        any = 1'b0;
        for (int i = 0; i < 16; i++) any = any | m_pend[i];
        chk("pending",   bus.pending, m_pend_vec());
        chk("out_valid", bus.out_valid, m_vld);
        chk("code",      {bus.A, bus.B, bus.C, bus.D}, m_code);
        chk("overrun",   bus.overrun, m_ovr);
        chk("busy",      bus.busy, any | m_vld);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pending"}, bus.pending, 16'h0000);
        chk({tag, "_valid"},   bus.out_valid, 1'b0);
        chk({tag, "_code"},    {bus.A, bus.B, bus.C, bus.D}, 4'b0000);
        chk({tag, "_overrun"}, bus.overrun, 1'b0);
        chk({tag, "_busy"},    bus.busy, 1'b0);
    endtask

    task automatic cycle(input logic [15:0] iv, input logic rdy);
        @(negedge clk);
        bus.in        = iv;
        bus.out_ready = rdy;
        model_step(iv, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic count_code(input int code, output int n);
        n = 0;
        foreach (accepted[k]) if (accepted[k] == code) n++;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        bus.in        = 16'h0000;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        model_reset();

        // Reset held with requests toggling: everything stays idle.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
            @(posedge clk);
            #1;
            check_idle("reset");
        end
        @(negedge clk);
        bus.in = 16'h0000;
        rst_n  = 1'b1;
        cycle(16'h0000, 1'b1);
        check_idle("post_reset");

        // Single request on line 5 with the consumer ready.
        cycle(16'h0020, 1'b1);
        chk("single_pend", bus.pending, 16'h0020);
        cycle(16'h0000, 1'b1);
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_code", {bus.A, bus.B, bus.C, bus.D}, 4'b0101);
        chk("single_pend0", bus.pending, 16'h0000);
        cycle(16'h0000, 1'b1);
        chk("single_done", bus.out_valid, 1'b0);
        chk("single_busy", bus.busy, 1'b0);

        // Priority order under back-pressure.
        accepted.delete();
        cycle(16'h8401, 1'b0);
        cycle(16'h0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(16'h0000, 1'b0);
            chk("hold_code", {bus.A, bus.B, bus.C, bus.D}, 4'b1111);
        end
        for (int k = 0; k < 4; k++) cycle(16'h0000, 1'b1);
        chk("prio_n", accepted.size(), 3);
        if (accepted.size() == 3) begin
            chk("prio_0", accepted[0], 15);
            chk("prio_1", accepted[1], 10);
            chk("prio_2", accepted[2], 0);
        end
        chk("prio_idle", bus.out_valid, 1'b0);

        // Overrun: line 3 requested twice while the output stage is stalled on line 5.
        accepted.delete();
        cycle(16'h0020, 1'b0);
        cycle(16'h0008, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h0008, 1'b0);
        chk("ovr_pulse", bus.overrun, 1'b1);
        cycle(16'h0000, 1'b0);
        chk("ovr_clear", bus.overrun, 1'b0);
        for (int k = 0; k < 4; k++) cycle(16'h0000, 1'b1);
        count_code(3, n);
        chk("ovr_once", n, 1);

        // Same-cycle re-request on the line being loaded.
        accepted.delete();
        cycle(16'h0004, 1'b1);
        cycle(16'h0004, 1'b1);
        chk("rereq_ovr", bus.overrun, 1'b0);
        chk("rereq_pend", bus.pending, 16'h0004);
        for (int k = 0; k < 3; k++) cycle(16'h0000, 1'b1);
        count_code(2, n);
        chk("rereq_twice", n, 2);

        // Random traffic with random back-pressure.
        for (int k = 0; k < 1500; k++) begin
            logic [15:0] iv;
            iv = 16'h0000;
            if ($urandom_range(0, 3) == 0) iv = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) iv = 16'($urandom);
            cycle(iv, logic'($urandom_range(0, 2) != 0));
        end

        // Reset asserted between edges while stalled with many requests.
        cycle(16'hFFFF, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h0000, 1'b0);
        chk("mid_busy_before", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(16'h0000, 1'b1);
        check_idle("mid_release");
        cycle(16'h0100, 1'b1);
        cycle(16'h0000, 1'b1);
        chk("after_code", {bus.A, bus.B, bus.C, bus.D}, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enc16to4_req.md
# enc16to4_req

Sequential 16-to-4 request encoder: the inverse of the 4-to-16 decoder path. It captures single-cycle request pulses on 16 one-hot lines into a pending bitmap, then issues the index of each pending request, highest-numbered line first, as a 4-bit code {A,B,C,D} through a valid/ready handshake. The code output is bit-compatible with the decoder's {A,B,C,D} input, so a downstream decoder regenerates the original line. The block sits between event sources and the consumer that serialises them.

## Interface
Parameters: none. Width fixed at 16 lines / 4-bit code.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in  input  16  request pulses; in[i]=1 for one cycle raises request i
- out_ready  input  1  consumer accepts the current code when high together with out_valid
- out_valid  output  1  {A,B,C,D} holds a valid code
- A  output  1  code bit 3 (MSB)
- B  output  1  code bit 2
- C  output  1  code bit 1
- D  output  1  code bit 0 (LSB)
- pending  output  16  registered pending bitmap, excluding the entry held in the output stage
- overrun  output  1  one-cycle pulse: a request arrived for a line already pending
- busy  output  1  |pending | out_valid

Reset: the interface uses one clock, clk, and reset is asynchronous and active-low, rst_n. While rst_n=0, pending=0, out_valid=0, {A,B,C,D}=4'b0000, overrun=0, busy=0. These values take effect immediately, without waiting for a clock edge. Any request in flight is discarded.

## Operation
- Priority select: sel = index of the highest set bit of the registered pending. It is combinational and valid only when pending≠0.
- Load condition: load = (pending≠0) & (!out_valid | out_ready).
- On load: {A,B,C,D} <= sel, out_valid <= 1, and bit sel is cleared from pending in the same edge. The issued bit moves out of pending into the output stage.
- Pending update: pending_next = (pending & ~(load ? onehot(sel) : 0)) | in.
- Simultaneous events:
  - If in[sel] is high in the cycle sel is loaded, bit sel stays set. The new event is preserved and reissued later.
  - An in[i] pulse for a line currently held in the output stage sets pending[i]. This is not an overrun.
- Overrun: overrun <= |(in & pending & ~(load ? onehot(sel) : 0)). The duplicate request merges and is counted once.
- Accept: an edge with out_valid & out_ready & !load sets out_valid <= 0. {A,B,C,D} keeps its last value, which is don't-care when invalid.
- Output stability: while out_valid=1 and out_ready=0, {A,B,C,D} must not change.
- Ordering: there is no age ordering. A newly arriving higher index overtakes older lower-index requests at the next load. Starvation of low indices under sustained high-index traffic is accepted behaviour.

## Timing
- Latency: an in[i] pulse sampled at edge N sets pending[i] after edge N. With an empty output stage or out_ready=1, out_valid=1 with code i appears after edge N+1. Latency is 2 cycles.
- Throughput: 1 code per cycle while out_ready=1 and pending≠0.
- overrun is registered and appears 1 cycle after the offending in pulse.
- busy is combinational from registered state.
- Reset asserted mid-transfer clears all state asynchronously. After rst_n deasserts, the first edge samples in normally.

## Test plan
- Reset: hold rst_n=0 with in=16'hFFFF toggling -> out_valid=0, pending=0, ABCD=0000, busy=0 throughout. Deassert rst_n with in=0 -> outputs stay idle.
- Single request, out_ready=1: pulse in=16'h0020 at edge 0 -> pending=16'h0020 after edge 0. After edge 1: out_valid=1, ABCD=0101, pending=0. After edge 2: out_valid=0, busy=0.
- Priority and back-pressure: pulse in=16'h8401 with out_ready=0 -> codes 1111 appears and is held stable for 5 cycles. Then out_ready=1 -> codes 1111, 1010, 0000 on consecutive accepts, then out_valid=0.
- Overrun: pulse in[3] at cycle 0 with out_ready=0 and out_valid held on another code, then pulse in[3] again at cycle 2 -> overrun=1 for exactly one cycle after cycle 2, and code 0011 is issued once.
- Same-cycle re-request: with pending=16'h0004, out_ready=1, pulse in[2] on the load edge -> code 0010 is issued twice, on consecutive cycles, with no overrun.
- Reset mid-operation: load pending=16'hFFFF and stall with out_ready=0. Assert rst_n=0 between edges -> out_valid, pending and busy drop to 0 immediately.
